// File: rtl/cpu_sequencer.sv
// cpu_sequencer: top-level control unit of the 8-bit accumulator CPU.
// Owns PC, AR, IR, AC, DR and E. It steps the fetch / decode / indirect /
// execute sequence with a 3-bit sequence counter. It drives the external
// memory and ALU ports.
//
// state | meaning
// IDLE  | after reset; SC held at 0, waiting for a start pulse
// RUN   | executing instructions, SC stepping T0..T5
// HALT  | HLT executed; registers frozen until the next start pulse
module cpu_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [2:0]        alu_sel,
    output logic [DATA_W-1:0] alu_ac,
    output logic [DATA_W-1:0] alu_dr,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    output logic [DATA_W-1:0] ac,
    output logic [ADDR_W-1:0] pc,
    output logic              e_flag,
    output logic [2:0]        sc,
    output logic              halted
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_CMA = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] ar_r;
    logic [DATA_W-1:0] ir_r;
    logic [DATA_W-1:0] ac_r;
    logic [DATA_W-1:0] dr_r;
    logic              e_r;
    logic [2:0]        sc_r;
    logic [2:0]        opcode;

    assign opcode    = ir_r[6:4];

    assign mem_addr  = ar_r;
    assign mem_wdata = ac_r;
    assign alu_sel   = opcode;
    assign alu_ac    = ac_r;
    assign alu_dr    = dr_r;
    assign ac        = ac_r;
    assign pc        = pc_r;
    assign e_flag    = e_r;
    assign sc        = sc_r;
    assign halted    = (state == ST_HALT);

    // Write strobe only in STA T4; gated by RST so a reset landing on that edge never writes.
    assign mem_we = (state == ST_RUN) && (sc_r == 3'd4) && (opcode == OP_STA) && !RST;

    // Top FSM and per-step register transfers; RST overrides everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            pc_r  <= '0;
            ar_r  <= '0;
            ir_r  <= '0;
            ac_r  <= '0;
            dr_r  <= '0;
            e_r   <= 1'b0;
            sc_r  <= 3'd0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    sc_r <= 3'd0;
                    if (start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sc_r <= sc_r + 3'd1;
                    case (sc_r)
                        3'd0: ar_r <= pc_r;
                        3'd1: begin
                            ir_r <= mem_rdata;
                            pc_r <= pc_r + ADDR_W'(1);
                        end
                        3'd2: ar_r <= ir_r[ADDR_W-1:0];
                        3'd3: begin
                            if (ir_r[7]) begin
                                ar_r <= mem_rdata[ADDR_W-1:0];
                            end
                        end
                        3'd4: begin
                            case (opcode)
                                OP_ADD, OP_SUB, OP_XOR, OP_LDA: dr_r <= mem_rdata;
                                OP_STA: sc_r <= 3'd0;
                                OP_SHL: begin
                                    ac_r <= alu_result;
                                    e_r  <= alu_cout;
                                    sc_r <= 3'd0;
                                end
                                OP_CMA: begin
                                    ac_r <= alu_result;
                                    sc_r <= 3'd0;
                                end
                                OP_HLT: begin
                                    state <= ST_HALT;
                                    sc_r  <= 3'd0;
                                end
                            endcase
                        end
                        3'd5: begin
                            case (opcode)
                                OP_ADD, OP_SUB: begin
                                    ac_r <= alu_result;
                                    e_r  <= alu_cout;
                                end
                                OP_XOR: ac_r <= alu_result;
                                OP_LDA: ac_r <= dr_r;
                                default: ;
                            endcase
                            sc_r <= 3'd0;
                        end
                        default: sc_r <= 3'd0;
                    endcase
                end
                default: begin
                    state <= ST_IDLE;
                    sc_r  <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Control unit for the 8-bit accumulator CPU, with a 16x8 memory, 4-bit PC/AR, 8-bit IR and a 3-bit sequence counter SC.
- Owns PC, AR, IR, AC, DR and E.
- Runs the fetch / decode / indirect / execute sequence and drives the external memory and the external ALU (opcode select, AC/DR operands in, result/carry back).
- Sits between the memory array and the ALU as the top-level sequencer of the CPU.

Parameters:
- ADDR_W, 4, memory address width (PC, AR, IR[3:0]).
- DATA_W, 8, data, IR, AC and DR width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; leaves IDLE or HALT and starts fetching at the current PC.
- mem_addr  output  ADDR_W  memory address; always equals AR.
- mem_rdata  input  DATA_W  memory read data; combinational, valid in the same cycle as mem_addr.
- mem_wdata  output  DATA_W  write data; always equals AC.
- mem_we  output  1  write strobe; memory writes on this rising CLK.
- alu_sel  output  3  ALU selector; equals the opcode in IR[6:4].
- alu_ac  output  DATA_W  ALU AC operand (AC register).
- alu_dr  output  DATA_W  ALU DR operand (DR register).
- alu_result  input  DATA_W  combinational ALU result.
- alu_cout  input  1  combinational ALU carry/borrow-out.
- ac  output  DATA_W  accumulator (observation).
- pc  output  ADDR_W  program counter (observation).
- e_flag  output  1  E register.
- sc  output  3  sequence counter value.
- halted  output  1  high while in HALT.

Behaviour:
- Instruction format:
  - IR[7] = I (indirect).
  - IR[6:4] = opcode.
  - IR[3:0] = address.
- Opcodes:
  - 000 ADD, 001 SUB, 010 XOR: AC <= alu_result with DR = M[ea].
  - 011 SHL: AC <= alu_result (AC+AC); no operand.
  - 100 LDA: AC <= M[ea].
  - 101 STA: M[ea] <= AC.
  - 110 CMA: AC <= alu_result (~AC); no operand.
  - 111 HLT.
- Top FSM states: IDLE, RUN, HALT.
- Reset (RST=1 at a rising CLK, overrides everything, including mid-instruction):
  - PC, AR, IR, AC, DR, E and SC all go to 0.
  - State goes to IDLE; mem_we=0, halted=0.
- IDLE: SC held at 0; a start pulse moves to RUN. start is ignored while in RUN.
- RUN timing: SC advances by 1 per cycle and returns to 0 at the end of each instruction.
  - T0: AR <= PC.
  - T1: IR <= mem_rdata; PC <= PC+1. PC wraps 15 -> 0.
  - T2: AR <= IR[3:0].
  - T3: if I=1, AR <= mem_rdata[3:0]; otherwise no-op. T3 always occupies one cycle.
  - T4, memory-reference ops (ADD/SUB/XOR/LDA): DR <= mem_rdata.
  - T4, STA: mem_we=1 for exactly this cycle; SC <= 0.
  - T4, SHL/CMA: AC <= alu_result. SHL also does E <= alu_cout. SC <= 0.
  - T4, HLT: state goes to HALT; SC <= 0.
  - T5, ADD/SUB/XOR: AC <= alu_result. ADD and SUB also do E <= alu_cout; XOR leaves E unchanged.
  - T5, LDA: AC <= DR.
  - End of T5: SC <= 0.
- Instruction latency:
  - 6 cycles: ADD, SUB, XOR, LDA.
  - 5 cycles: STA, SHL, CMA, HLT.
  - Indirect addressing costs no extra cycles.
- mem_we is 0 in every cycle except STA at T4.
- HALT:
  - halted=1; all registers hold.
  - start resumes RUN at the current PC (the instruction after HLT).
- A start pulse coincident with RST is ignored.
- Indirect pointer: only the low ADDR_W bits of the pointer word are used.

Test Plan:
- Straight-line program. M[0]=0x4A, M[1]=0x0B, M[2]=0x5C, M[3]=0x70, M[A]=0x05, M[B]=0x03. Reset, then pulse start.
  -> M[C]=0x08, AC=0x08, E=0.
  -> halted rises exactly 23 cycles after the start cycle; pc=4.
- Indirect load. M[0]=0xCD, M[D]=0x1A, M[A]=0x77.
  -> AC=0x77 after 6 cycles; mem_addr=0xA during T4.
- Carry / borrow with a golden ALU model. AC=0xFF, then ADD of a word holding 0x01.
  -> AC=0x00, E=1.
  -> A following SUB of 0x05 from 0x03 gives AC=0xFE, E=alu_cout as the ALU model supplies it.
- SHL/CMA. AC=0x81; SHL -> AC=0x02, E=1, 5 cycles. CMA -> AC=0xFD.
- PC wrap. HLT at M[F], start with PC=0xF -> halted=1, pc=0x0. start again -> fetches M[0].
- Reset mid-instruction. Assert RST during T4 of an STA -> no memory write occurs; the next cycle shows all registers 0, SC=0, state IDLE, mem_we=0.
